// File: rtl/ysyx_22040237_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
package ysyx_22040237_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_IF_REQ, S_IF_WAIT, S_ID, S_EX, S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT
   } state_e;

   typedef struct packed {
      logic load;
      logic store;
      logic wr_rd;
      logic jump;
      logic multi;
   } dec_t;

   localparam int         NPC_ABORT    = 3;
   localparam logic [1:0] HALT_NONE    = 2'd0;
   localparam logic [1:0] HALT_EBREAK  = 2'd1;
   localparam logic [1:0] HALT_INVALID = 2'd2;
   localparam logic [1:0] HALT_TIMEOUT = 2'(NPC_ABORT);

endpackage

// File: rtl/ysyx_22040237_wait_timer.sv
// Wait-state watchdog: clears on state entry, counts stalled cycles, flags the last allowed one.
module ysyx_22040237_wait_timer #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   logic [TO_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (inc_i) cnt_q <= cnt_q + 1'b1;
   end

   assign expire_o = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_22040237_core_seq.sv
// Multi-cycle NPC sequencer with halt detection.
// Optional YSYX_22040237_PERF_CNT_EN adds cycle / retired-instruction counters.
module ysyx_22040237_core_seq
   import ysyx_22040237_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 10
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   input  logic        ifu_rsp_valid,
   output logic        ir_wen,
   input  logic        inst_ebreak,
   input  logic        invalid_inst,
   input  logic        inst_is_load,
   input  logic        inst_is_store,
   input  logic        inst_wr_rd,
   input  logic        inst_jump,
   input  logic        inst_multi,
   output logic        exu_en,
   input  logic        exu_done,
   output logic        lsu_req_valid,
   input  logic        lsu_req_ready,
   input  logic        lsu_rsp_valid,
   output logic        rf_wen,
   output logic        pc_wen,
   output logic        pc_sel_jump,
   output logic        retire,
   output logic        halted,
`ifdef YSYX_22040237_PERF_CNT_EN
   output logic [63:0] cyc_cnt,
   output logic [63:0] inst_cnt,
`endif
   output logic [1:0]  halt_code
);

   state_e     state_q, state_d;
   dec_t       dec_q;
   logic [1:0] halt_code_q, halt_code_d;
   logic       wait_st, exit_ok, expire;

   always_comb begin
      state_d       = state_q;
      halt_code_d   = halt_code_q;
      wait_st       = 1'b0;
      exit_ok       = 1'b0;
      ifu_req_valid = 1'b0;
      ir_wen        = 1'b0;
      exu_en        = 1'b0;
      lsu_req_valid = 1'b0;
      rf_wen        = 1'b0;
      pc_wen        = 1'b0;
      pc_sel_jump   = 1'b0;
      retire        = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_IF_REQ;
         S_IF_REQ: begin
            ifu_req_valid = 1'b1;
            wait_st       = 1'b1;
            exit_ok       = ifu_req_ready;
            if (exit_ok) state_d = S_IF_WAIT;
         end
         S_IF_WAIT: begin
            ir_wen  = ifu_rsp_valid;
            wait_st = 1'b1;
            exit_ok = ifu_rsp_valid;
            if (exit_ok) state_d = S_ID;
         end
         S_ID: begin
            if (invalid_inst) begin
               state_d     = S_HALT;
               halt_code_d = HALT_INVALID;
            end else if (inst_ebreak) begin
               state_d     = S_HALT;
               halt_code_d = HALT_EBREAK;
               retire      = 1'b1;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            exu_en  = 1'b1;
            wait_st = 1'b1;
            exit_ok = !dec_q.multi || exu_done;
            if (exit_ok) state_d = (dec_q.load || dec_q.store) ? S_MEM_REQ : S_WB;
         end
         S_MEM_REQ: begin
            lsu_req_valid = 1'b1;
            wait_st       = 1'b1;
            exit_ok       = lsu_req_ready;
            if (exit_ok) state_d = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            wait_st = 1'b1;
            exit_ok = lsu_rsp_valid;
            if (exit_ok) state_d = S_WB;
         end
         S_WB: begin
            rf_wen      = dec_q.wr_rd && !dec_q.store;
            pc_wen      = 1'b1;
            pc_sel_jump = dec_q.jump;
            retire      = 1'b1;
            state_d     = S_IF_REQ;
         end
         S_HALT: ;
         default: state_d = S_IDLE;
      endcase
      // A handshake completing on the limit cycle still wins.
      if (wait_st && !exit_ok && expire) begin
         state_d     = S_HALT;
         halt_code_d = HALT_TIMEOUT;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         halt_code_q <= HALT_NONE;
         dec_q       <= '0;
      end else begin
         state_q     <= state_d;
         halt_code_q <= halt_code_d;
         if (state_q == S_ID)
            dec_q <= '{load: inst_is_load, store: inst_is_store, wr_rd: inst_wr_rd,
                       jump: inst_jump, multi: inst_multi};
      end
   end

   ysyx_22040237_wait_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (state_d != state_q),
      .inc_i    (wait_st && !exit_ok),
      .expire_o (expire)
   );

   assign halted    = (state_q == S_HALT);
   assign halt_code = halt_code_q;

`ifdef YSYX_22040237_PERF_CNT_EN
   logic [63:0] cyc_cnt_q, inst_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_cnt_q  <= '0;
         inst_cnt_q <= '0;
      end else begin
         if (state_q != S_HALT) cyc_cnt_q  <= cyc_cnt_q + 64'd1;
         if (retire)            inst_cnt_q <= inst_cnt_q + 64'd1;
      end
   end

   assign cyc_cnt  = cyc_cnt_q;
   assign inst_cnt = inst_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22040237_core_seq.sv
// Scoreboard bench for the core sequencer: stimulus queues expected retire/halt events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ysyx_22040237_core_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ir_wen;
   logic inst_ebreak, invalid_inst, inst_is_load, inst_is_store;
   logic inst_wr_rd, inst_jump, inst_multi;
   logic exu_en, exu_done, lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
   logic rf_wen, pc_wen, pc_sel_jump, retire, halted;
   logic [1:0] halt_code;
`ifdef YSYX_22040237_PERF_CNT_EN
   logic [63:0] cyc_cnt, inst_cnt;
`endif

   ysyx_22040237_core_seq #(.TIMEOUT(4), .TO_W(10)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_rsp_valid(ifu_rsp_valid), .ir_wen(ir_wen),
      .inst_ebreak(inst_ebreak), .invalid_inst(invalid_inst),
      .inst_is_load(inst_is_load), .inst_is_store(inst_is_store),
      .inst_wr_rd(inst_wr_rd), .inst_jump(inst_jump), .inst_multi(inst_multi),
      .exu_en(exu_en), .exu_done(exu_done),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_rsp_valid(lsu_rsp_valid),
      .rf_wen(rf_wen), .pc_wen(pc_wen), .pc_sel_jump(pc_sel_jump),
      .retire(retire), .halted(halted),
`ifdef YSYX_22040237_PERF_CNT_EN
      .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt),
`endif
      .halt_code(halt_code)
   );

   always #5 clk = ~clk;

   // kind 0 = retire, 1 = halt entry
   typedef struct {
      int         kind;
      int         cyc;
      logic       rf;
      logic       pcw;
      logic       jmp;
      logic [1:0] code;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc;
   int   lsu_vld_total = 0;
   int   lsu_v0;
   logic halted_prev = 1'b0;

   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic int all_outs();
      return int'({ifu_req_valid, ir_wen, exu_en, lsu_req_valid, rf_wen, pc_wen,
                   pc_sel_jump, retire, halted, halt_code});
   endfunction

   function automatic int enables();
      return int'({ifu_req_valid, ir_wen, exu_en, lsu_req_valid, rf_wen, pc_wen,
                   pc_sel_jump, retire});
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         if (lsu_req_valid) lsu_vld_total++;
         if (retire) begin
            if (q.size() == 0) chk("unexpected_retire", 1, 0);
            else begin
               mon_e = q.pop_front();
               chk("retire_kind", 0, mon_e.kind);
               chk("retire_cyc", cyc, mon_e.cyc);
               chk("retire_rf_wen", rf_wen, mon_e.rf);
               chk("retire_pc_wen", pc_wen, mon_e.pcw);
               chk("retire_pc_sel_jump", pc_sel_jump, mon_e.jmp);
            end
         end
         if (halted && !halted_prev) begin
            if (q.size() == 0) chk("unexpected_halt", 1, 0);
            else begin
               mon_e = q.pop_front();
               chk("halt_kind", 1, mon_e.kind);
               chk("halt_cyc", cyc, mon_e.cyc);
               chk("halt_code", halt_code, mon_e.code);
            end
         end
      end
      halted_prev = halted;
   end

   task automatic push_ret(input int c, input logic rf, input logic pcw, input logic jmp);
      exp_t e;
      e.kind = 0; e.cyc = c; e.rf = rf; e.pcw = pcw; e.jmp = jmp; e.code = 2'd0;
      q.push_back(e);
   endtask

   task automatic push_halt(input int c, input logic [1:0] code);
      exp_t e;
      e.kind = 1; e.cyc = c; e.rf = 1'b0; e.pcw = 1'b0; e.jmp = 1'b0; e.code = code;
      q.push_back(e);
   endtask

   // cyc always advances, so this is bounded by construction
   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic set_dec(input logic ld, input logic st, input logic wr, input logic jmp,
                          input logic mul, input logic ebk, input logic inv);
      inst_is_load = ld; inst_is_store = st; inst_wr_rd = wr; inst_jump = jmp;
      inst_multi = mul; inst_ebreak = ebk; invalid_inst = inv;
   endtask

   task automatic reset_cycle();
      rst = 1'b0;
      #1 chk("reset_outs", all_outs(), 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("idle_outs", all_outs(), 0);
      wait_cyc(1);
      chk("ifu_req_cyc1", ifu_req_valid, 1);
   endtask

   initial begin
      ifu_req_ready = 1; ifu_rsp_valid = 1; exu_done = 1;
      lsu_req_ready = 1; lsu_rsp_valid = 1;
      set_dec(0, 0, 1, 0, 0, 0, 0);

      // ALU op, everything immediate: WB in cycle 5
      push_ret(5, 1, 1, 0);
      reset_cycle();
      wait_cyc(5);

      // store with wr_rd=1: rf_wen suppressed
      set_dec(0, 1, 1, 0, 0, 0, 0);
      push_ret(12, 0, 1, 0);
      wait_cyc(12);

      // jump
      set_dec(0, 0, 1, 1, 0, 0, 0);
      push_ret(17, 1, 1, 1);
      wait_cyc(17);

      // multi-cycle EXU, done on third EX cycle
      set_dec(0, 0, 1, 0, 1, 0, 0);
      exu_done = 0;
      push_ret(24, 1, 1, 0);
      wait_cyc(22);
      chk("exu_en_held", exu_en, 1);
      wait_cyc(23);
      exu_done = 1;
      wait_cyc(24);

      // load: ready on 4th MEM_REQ cycle (timeout limit) alongside a stray rsp
      set_dec(1, 0, 1, 0, 0, 0, 0);
      lsu_req_ready = 0; lsu_rsp_valid = 0;
      lsu_v0 = lsu_vld_total;
      push_ret(35, 1, 1, 0);
      wait_cyc(32);
      lsu_req_ready = 1; lsu_rsp_valid = 1;
      wait_cyc(33);
      lsu_rsp_valid = 0;
      chk("mem_wait_no_req", lsu_req_valid, 0);
      wait_cyc(34);
      chk("rf_wen_before_rsp", rf_wen, 0);
      lsu_rsp_valid = 1;
      wait_cyc(35);
      chk("lsu_req_valid_cycles", lsu_vld_total - lsu_v0, 4);

      // IF response arrives on the 4th IF_WAIT cycle: exit beats timeout
      set_dec(0, 0, 0, 0, 0, 0, 0);
      ifu_rsp_valid = 0;
      push_ret(43, 0, 1, 0);
      wait_cyc(40);
      chk("not_halted_at_limit", halted, 0);
      ifu_rsp_valid = 1;
      wait_cyc(43);

      // reset during MEM_WAIT drops the instruction
      set_dec(1, 0, 1, 0, 0, 0, 0);
      lsu_rsp_valid = 0;
      wait_cyc(48);
      chk("mem_req_48", lsu_req_valid, 1);
      wait_cyc(49);
      chk("mem_wait_49", lsu_req_valid, 0);
`ifdef YSYX_22040237_PERF_CNT_EN
      chk("inst_cnt_before_rst", inst_cnt, 6);
`endif
      #2;
      reset_cycle();
`ifdef YSYX_22040237_PERF_CNT_EN
      chk("inst_cnt_after_rst", inst_cnt, 0);
`endif
      lsu_rsp_valid = 1;

      // invalid + ebreak: invalid has priority, no retire
      set_dec(0, 0, 1, 0, 0, 1, 1);
      push_halt(4, 2'd2);
      reset_cycle();
      wait_cyc(8);
      chk("halted_invalid", halted, 1);
      chk("halt_code_held", halt_code, 2);
      chk("halt_enables_off", enables(), 0);
`ifdef YSYX_22040237_PERF_CNT_EN
      chk("cyc_cnt_frozen", cyc_cnt, 4);
`endif

      // ebreak alone: retire in ID, then halt code 1
      set_dec(0, 0, 1, 0, 0, 1, 0);
      push_ret(3, 0, 0, 0);
      push_halt(4, 2'd1);
      reset_cycle();
      wait_cyc(8);
      chk("halt_code_ebreak", halt_code, 1);

      // IF response never arrives: timeout after 4 IF_WAIT cycles
      set_dec(0, 0, 1, 0, 0, 0, 0);
      ifu_rsp_valid = 0;
      push_halt(6, 2'd3);
      reset_cycle();
      wait_cyc(5);
      chk("not_halted_cyc5", halted, 0);
      wait_cyc(8);
      chk("halt_code_timeout", halt_code, 3);
      chk("timeout_enables_off", enables(), 0);

      wait_cyc(10);
      chk("scoreboard_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22040237_core_seq.md
Name: ysyx_22040237_core_seq

Overview:
Multi-cycle sequencer for the NPC core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enables for the IFU, the instruction register, the EXU, the LSU, the register file and the PC. It replaces the implicit one-instruction-per-clock timing of the single-cycle core. It also owns simulation-halt detection (ebreak, invalid instruction, bus timeout) and reports the halt cause.

Parameters:
TIMEOUT, 255, maximum cycles spent in any wait state before aborting; legal range 1..1023.
TO_W, 10, width of the timeout counter.

Ports:
clk  input  1  core clock
rst  input  1  reset; asynchronous, active-low
ifu_req_valid  output  1  fetch request
ifu_req_ready  input  1  IFU accepts request
ifu_rsp_valid  input  1  instruction word available
ir_wen  output  1  latch the instruction register
inst_ebreak  input  1  decode: ebreak (valid in ID)
invalid_inst  input  1  decode: illegal opcode (valid in ID)
inst_is_load  input  1  decode: load (valid in ID)
inst_is_store  input  1  decode: store (valid in ID)
inst_wr_rd  input  1  decode: writes rd (valid in ID)
inst_jump  input  1  decode: branch taken or jump (valid in ID)
inst_multi  input  1  decode: multi-cycle EXU op (valid in ID)
exu_en  output  1  EXU operate
exu_done  input  1  multi-cycle EXU result ready
lsu_req_valid  output  1  memory request
lsu_req_ready  input  1  LSU accepts request
lsu_rsp_valid  input  1  load data ready or store complete
rf_wen  output  1  register-file write
pc_wen  output  1  PC update
pc_sel_jump  output  1  1 = pc_jump_addr, 0 = pc+4
retire  output  1  one-cycle pulse per retired instruction
halted  output  1  core stopped
halt_code  output  2  0 none, 1 ebreak, 2 invalid, 3 timeout

Behaviour:
- States: IDLE, IF_REQ, IF_WAIT, ID, EX, MEM_REQ, MEM_WAIT, WB, HALT. Encoding is binary and registered.
- Reset: state=IDLE, to_cnt=0, all latched decode flags 0, halted=0, halt_code=0. All outputs 0 while reset is asserted. If reset asserts mid-instruction, the instruction is dropped with no writes.
- IDLE -> IF_REQ unconditionally. This gives a one-cycle bubble after reset release.
- IF_REQ: ifu_req_valid=1. Leave on ifu_req_ready, going to IF_WAIT.
- IF_WAIT: ir_wen=ifu_rsp_valid. Leave on ifu_rsp_valid, going to ID.
- ID: sample the decode inputs into flag registers. Priority, highest first:
  - invalid_inst -> HALT, code 2. No retire.
  - inst_ebreak -> HALT, code 1. retire pulses in this cycle.
  - otherwise -> EX.
- EX: exu_en=1.
  - If multi=0, leave after one cycle.
  - If multi=1, hold until exu_done.
  - Exit goes to MEM_REQ if load or store, else WB.
- MEM_REQ: lsu_req_valid=1. Leave on lsu_req_ready, going to MEM_WAIT.
- MEM_WAIT: leave on lsu_rsp_valid, going to WB. EXU result stays stable because its operands are held by the IR.
- WB, exactly one cycle:
  - rf_wen=wr_rd flag; stores force rf_wen=0.
  - pc_wen=1, pc_sel_jump=jump flag, retire=1.
  - Next state IF_REQ.
- Minimum latency for a non-memory single-cycle op: 5 cycles (IF_REQ, IF_WAIT, ID, EX, WB), given immediate ready/valid.
- Handshakes:
  - Request valids stay asserted until ready; they never drop early.
  - Simultaneous req_ready and rsp_valid in a REQ state is ignored. Only ready is consumed; the response is expected in the WAIT state.
- Timeout:
  - to_cnt clears on entering IF_REQ, IF_WAIT, EX, MEM_REQ or MEM_WAIT, and increments each cycle the exit condition is false.
  - When to_cnt==TIMEOUT-1 and the exit condition is still false, go to HALT with code 3.
  - An exit on the same cycle as the limit wins over the timeout.
- HALT: absorbing until reset. halted=1, halt_code held, all enables 0.
- Decode inputs are ignored outside ID.

Optional Feature:
YSYX_22040237_PERF_CNT_EN: adds outputs cyc_cnt[63:0] and inst_cnt[63:0].
- cyc_cnt counts every non-reset cycle; it stops once halted.
- inst_cnt increments on retire. Both wrap modulo 2^64 and reset to 0.
- Without the macro, neither port nor counter exists.

Decomposition:
- Shared package ysyx_22040237_pkg holds:
  - the state enum
  - halt_code constants HALT_NONE/EBREAK/INVALID/TIMEOUT
  - the NPC_ABORT value 3 used by the halt DPI path
- One natural sub-module: ysyx_22040237_wait_timer. It implements the to_cnt counter with clear, increment and expire outputs, parameterised by TIMEOUT and TO_W.

Test Plan:
1. ALU op, all ready/valid immediate, wr_rd=1, jump=0 -> ifu_req_valid at cycle 1 after reset release; rf_wen=pc_wen=retire=1 in cycle 5; pc_sel_jump=0.
2. Load, lsu_req_ready delayed 3 cycles, lsu_rsp_valid 2 cycles later -> lsu_req_valid high 4 consecutive cycles; rf_wen exactly once, after rsp.
3. Store with inst_wr_rd=1, jump op -> store: rf_wen=0 throughout. Jump: pc_sel_jump=1 in WB.
4. ID with inst_ebreak=1 and invalid_inst=1 both set -> HALT, halt_code=2, no retire. Repeat with only ebreak -> halt_code=1, retire once.
5. TIMEOUT=4, ifu_rsp_valid never asserted -> HALT after exactly 4 IF_WAIT cycles, halt_code=3; rsp at cycle 4 instead -> proceeds to ID.
6. Reset asserted in MEM_WAIT -> all outputs 0 immediately (async); after release, IDLE then IF_REQ; with PERF_CNT_EN, inst_cnt=0.
